// File: rtl/dev_input_pkg.sv
// rtl/dev_input_pkg.sv - shared constants and default debounce derivation for the input debouncer
package dev_input_pkg;

    localparam int DEV_INPUT_WIDTH  = 21;

    // Bit positions of the board inputs within pins_i
    localparam int DEV_INPUT_SW_LSB = 0;
    localparam int DEV_INPUT_SW_MSB = 15;
    localparam int DEV_INPUT_BTND   = 16;
    localparam int DEV_INPUT_BTNR   = 17;
    localparam int DEV_INPUT_BTNL   = 18;
    localparam int DEV_INPUT_BTNU   = 19;
    localparam int DEV_INPUT_BTNC   = 20;

    // 5 ms worth of clock cycles, never below one so the counter stays meaningful
    function automatic int dev_input_default_debounce(input int clock_frequency);
        int cycles;
        cycles = clock_frequency / 200;
        return (cycles < 1) ? 1 : cycles;
    endfunction

endpackage

// File: rtl/dev_input_debounce_ch.sv
// rtl/dev_input_debounce_ch.sv - one input channel: 2-flop sync, stability counter, level and edge pulses (glitch flag with DEV_INPUT_GLITCH_CNT_EN)
module dev_input_debounce_ch import dev_input_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
`ifdef DEV_INPUT_GLITCH_CNT_EN
    output logic glitch,
`endif
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall,
    output logic rise_nxt,
    output logic fall_nxt
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          level_nxt;
    logic          commit;

    // Count consecutive cycles where the synchronised pin disagrees with the accepted level
    always_comb begin
        cnt_nxt   = cnt;
        level_nxt = level;
        commit    = 1'b0;
        if (s2 == level) begin
            cnt_nxt = '0;
        end else if (cnt == LAST) begin
            commit    = 1'b1;
            level_nxt = s2;
            cnt_nxt   = '0;
        end else begin
            cnt_nxt = cnt + CW'(1);
        end
    end

    assign rise_nxt = commit & s2;
    assign fall_nxt = commit & ~s2;

`ifdef DEV_INPUT_GLITCH_CNT_EN
    // A bounce: pin fell back to the accepted level after partial credit had been counted
    assign glitch = (s2 == level) && (cnt != '0);
`endif

    // Synchroniser, counter, level and pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            s1    <= pin;
            s2    <= s1;
            cnt   <= cnt_nxt;
            level <= level_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
        end
    end

endmodule

// File: rtl/dev_input_debounce.sv
// rtl/dev_input_debounce.sv - debounced switch/button inputs with edge pulses and sticky events (glitch counter with DEV_INPUT_GLITCH_CNT_EN)
module dev_input_debounce import dev_input_pkg::*; #(
    parameter int CLOCK_FREQUENCY = 100000000,
    parameter int DEBOUNCE_CYCLES = dev_input_default_debounce(CLOCK_FREQUENCY),
    parameter int WIDTH           = DEV_INPUT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
`ifdef DEV_INPUT_GLITCH_CNT_EN
    output logic [15:0]      glitch_cnt_o,
    input  logic             glitch_clr_i,
`endif
    input  logic [WIDTH-1:0] pins_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             changed_o,
    output logic [WIDTH-1:0] events_o,
    input  logic [WIDTH-1:0] clr_i
);

    logic [WIDTH-1:0] rise_nxt;
    logic [WIDTH-1:0] fall_nxt;
`ifdef DEV_INPUT_GLITCH_CNT_EN
    logic [WIDTH-1:0] glitch_vec;
    logic [15:0]      glitch_cnt_q;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        dev_input_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
`ifdef DEV_INPUT_GLITCH_CNT_EN
            .glitch   (glitch_vec[i]),
`endif
            .pin      (pins_i[i]),
            .level    (level_o[i]),
            .rise     (rise_o[i]),
            .fall     (fall_o[i]),
            .rise_nxt (rise_nxt[i]),
            .fall_nxt (fall_nxt[i])
        );
    end

    // Any-change pulse and sticky events, both built from next-state edges so they line up with the pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            changed_o <= 1'b0;
            events_o  <= '0;
        end else begin
            changed_o <= |(rise_nxt | fall_nxt);
            events_o  <= (events_o & ~clr_i) | rise_nxt | fall_nxt;
        end
    end

`ifdef DEV_INPUT_GLITCH_CNT_EN
    // Saturating count of cycles with at least one rejected bounce; clear beats increment
    always_ff @(posedge clk) begin
        if (rst) begin
            glitch_cnt_q <= '0;
        end else if (glitch_clr_i) begin
            glitch_cnt_q <= '0;
        end else if ((|glitch_vec) && (glitch_cnt_q != 16'hFFFF)) begin
            glitch_cnt_q <= glitch_cnt_q + 16'd1;
        end
    end

    assign glitch_cnt_o = glitch_cnt_q;
`endif

endmodule

// File: tb/tb_dev_input_debounce.sv
// tb/tb_dev_input_debounce.sv - self-checking bench for dev_input_debounce (table vectors plus cycle-tagged scoreboard)
module tb_dev_input_debounce;

    localparam int W = 21;
    localparam int D = 4;

    localparam logic [W-1:0] B0   = 21'h000001;
    localparam logic [W-1:0] B3   = 21'h000008;
    localparam logic [W-1:0] B5   = 21'h000020;
    localparam logic [W-1:0] B7   = 21'h000080;
    localparam logic [W-1:0] B16  = 21'h010000;
    localparam logic [W-1:0] B20  = 21'h100000;
    localparam logic [W-1:0] SW   = 21'h00FFFF;
    localparam logic [W-1:0] ALL  = 21'h1FFFFF;
    localparam logic [W-1:0] NONE = 21'h000000;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] pins;
    logic [W-1:0] clr;
    logic [W-1:0] level;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         changed;
    logic [W-1:0] events;
`ifdef DEV_INPUT_GLITCH_CNT_EN
    logic [15:0]  glitch_cnt;
    logic         glitch_clr = 1'b0;
`endif

    int cyc = 0;
    int total = 0;
    int bad = 0;

    dev_input_debounce #(
        .CLOCK_FREQUENCY (800),
        .DEBOUNCE_CYCLES (D),
        .WIDTH           (W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef DEV_INPUT_GLITCH_CNT_EN
        .glitch_cnt_o (glitch_cnt),
        .glitch_clr_i (glitch_clr),
`endif
        .pins_i       (pins),
        .level_o      (level),
        .rise_o       (rise),
        .fall_o       (fall),
        .changed_o    (changed),
        .events_o     (events),
        .clr_i        (clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           cyc;
        string        name;
        logic [W-1:0] lvl;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         chg;
        logic [W-1:0] ev;
    } exp_t;

    typedef struct {
        string        name;
        logic [W-1:0] pins;
        logic [W-1:0] clr;
        int           edges;
        logic [W-1:0] lvl;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         chg;
        logic [W-1:0] ev;
    } vec_t;

    exp_t sb[$];

    task automatic drive(input logic [W-1:0] p, input logic [W-1:0] c);
        pins = p;
        clr  = c;
    endtask

    // Expect these outputs at the falling edge after k more rising edges
    task automatic expect_at(input int k, input string name, input logic [W-1:0] l,
                             input logic [W-1:0] r, input logic [W-1:0] f,
                             input logic c, input logic [W-1:0] e);
        exp_t x;
        x.cyc = cyc + k; x.name = name;
        x.lvl = l; x.rise = r; x.fall = f; x.chg = c; x.ev = e;
        sb.push_back(x);
    endtask

    task automatic advance(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        vec_t vecs[14];
        int   bounce[8];
        exp_t x;

        vecs[0]  = '{"clean_pre",    B0,       NONE, 5, NONE,     NONE, NONE,     1'b0, NONE};
        vecs[1]  = '{"clean_rise",   B0,       NONE, 1, B0,       B0,   NONE,     1'b1, B0};
        vecs[2]  = '{"clean_after",  B0,       NONE, 1, B0,       NONE, NONE,     1'b0, B0};
        vecs[3]  = '{"fall_pre",     NONE,     NONE, 5, B0,       NONE, NONE,     1'b0, B0};
        vecs[4]  = '{"fall_pulse",   NONE,     NONE, 1, NONE,     NONE, B0,       1'b1, B0};
        vecs[5]  = '{"clr_all",      NONE,     ALL,  1, NONE,     NONE, NONE,     1'b0, NONE};
        vecs[6]  = '{"btnd_rise",    B16,      NONE, 6, B16,      B16,  NONE,     1'b1, B16};
        vecs[7]  = '{"btnd_clr",     B16,      ALL,  1, B16,      NONE, NONE,     1'b0, NONE};
        vecs[8]  = '{"simul_swap",   B20,      NONE, 6, B20,      B20,  B16,      1'b1, B20 | B16};
        vecs[9]  = '{"simul_after",  B20,      NONE, 1, B20,      NONE, NONE,     1'b0, B20 | B16};
        vecs[10] = '{"all_sw_rise",  B20 | SW, NONE, 6, B20 | SW, SW,   NONE,     1'b1, B20 | B16 | SW};
        vecs[11] = '{"all_sw_clr",   B20 | SW, ALL,  1, B20 | SW, NONE, NONE,     1'b0, NONE};
        vecs[12] = '{"all_fall",     NONE,     NONE, 6, NONE,     NONE, B20 | SW, 1'b1, B20 | SW};
        vecs[13] = '{"idle_clr",     NONE,     ALL,  1, NONE,     NONE, NONE,     1'b0, NONE};
        bounce   = '{1, 1, 0, 0, 1, 1, 0, 0};

        fork
            begin : monitor
                forever begin
                    @(negedge clk);
                    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                        x = sb.pop_front();
                        total++;
                        if (x.cyc != cyc || level !== x.lvl || rise !== x.rise || fall !== x.fall ||
                            changed !== x.chg || events !== x.ev) begin
                            bad++;
                            $display("FAIL %s cyc=%0d/%0d level=%h/%h rise=%h/%h fall=%h/%h changed=%b/%b events=%h/%h (got/exp)",
                                     x.name, cyc, x.cyc, level, x.lvl, rise, x.rise, fall, x.fall,
                                     changed, x.chg, events, x.ev);
                        end
                    end
                end
            end
            begin : stimulus
                // Reset with pins high: everything must stay cleared
                rst = 1'b1;
                drive(ALL, NONE);
                expect_at(3, "reset", NONE, NONE, NONE, 1'b0, NONE);
                advance(3);
                rst = 1'b0;
                drive(NONE, NONE);

                for (int i = 0; i < 14; i++) begin
                    drive(vecs[i].pins, vecs[i].clr);
                    expect_at(vecs[i].edges, vecs[i].name, vecs[i].lvl, vecs[i].rise,
                              vecs[i].fall, vecs[i].chg, vecs[i].ev);
                    advance(vecs[i].edges);
                end

                // Bounce on bit 3: no pulse while toggling, level after final stable capture
                for (int i = 0; i < 8; i++) begin
                    drive((bounce[i] != 0) ? B3 : NONE, NONE);
                    expect_at(1, "bounce_quiet", NONE, NONE, NONE, 1'b0, NONE);
                    advance(1);
                end
                drive(B3, NONE);
                for (int k = 1; k <= 5; k++)
                    expect_at(k, "bounce_wait", NONE, NONE, NONE, 1'b0, NONE);
                expect_at(6, "bounce_rise", B3, B3, NONE, 1'b1, B3);
                advance(6);
`ifdef DEV_INPUT_GLITCH_CNT_EN
                total++;
                if (glitch_cnt !== 16'd2) begin
                    bad++;
                    $display("FAIL glitch_bounce got=%0d exp=2", glitch_cnt);
                end
`endif

                // Clear racing a new rise on bit 0: set wins, then a lone clear works
                drive(B3, ALL);
                expect_at(1, "race_prep", B3, NONE, NONE, 1'b0, NONE);
                advance(1);
                drive(B3 | B0, NONE);
                expect_at(5, "race_pre", B3, NONE, NONE, 1'b0, NONE);
                advance(5);
                drive(B3 | B0, B0);
                expect_at(1, "race_set_wins", B3 | B0, B0, NONE, 1'b1, B0);
                advance(1);
                drive(B3 | B0, B0);
                expect_at(1, "race_clear", B3 | B0, NONE, NONE, 1'b0, NONE);
                advance(1);

                // Reset in the middle of bit 5's count, then a full count from scratch
                drive(B3 | B0 | B5, NONE);
                advance(4);
                rst = 1'b1;
                expect_at(1, "midcount_rst", NONE, NONE, NONE, 1'b0, NONE);
                advance(1);
                rst = 1'b0;
                for (int k = 1; k <= 5; k++)
                    expect_at(k, "post_rst_wait", NONE, NONE, NONE, 1'b0, NONE);
                expect_at(6, "post_rst_rise", B3 | B0 | B5, B3 | B0 | B5, NONE, 1'b1, B3 | B0 | B5);
                advance(6);

`ifdef DEV_INPUT_GLITCH_CNT_EN
                // Saturation: start near the top and keep bouncing bit 7
                force dut.glitch_cnt_q = 16'hFFFE;
                #1;
                release dut.glitch_cnt_q;
                for (int r = 0; r < 2; r++) begin
                    for (int i = 0; i < 8; i++) begin
                        drive(((bounce[i] != 0) ? B7 : NONE) | B3 | B0 | B5, NONE);
                        advance(1);
                    end
                end
                advance(3);
                total++;
                if (glitch_cnt !== 16'hFFFF) begin
                    bad++;
                    $display("FAIL glitch_saturate got=%h exp=ffff", glitch_cnt);
                end
                glitch_clr = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    drive(((bounce[i] != 0) ? B7 : NONE) | B3 | B0 | B5, NONE);
                    advance(1);
                end
                advance(3);
                glitch_clr = 1'b0;
                total++;
                if (glitch_cnt !== 16'h0000) begin
                    bad++;
                    $display("FAIL glitch_clear got=%h exp=0000", glitch_cnt);
                end
`endif

                // Let the scoreboard drain, bounded
                for (int i = 0; i < 20 && sb.size() > 0; i++)
                    advance(1);
            end
        join_any
        disable fork;

        while (sb.size() > 0) begin
            x = sb.pop_front();
            total++;
            bad++;
            $display("FAIL %s timeout expected_cyc=%0d now=%0d", x.name, x.cyc, cyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
